// File: rtl/e_mdu_iter_pkg.sv
// Shared encodings for the iterative E-stage multiply/divide unit.
package e_mdu_iter_pkg;

   // Operation codes carried on MDType.
   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_type_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   // Datapath class for one bit-serial iteration.
   typedef enum logic {
      OPC_MUL = 1'b0,
      OPC_DIV = 1'b1
   } op_class_e;

   // True for opcodes that occupy the iterative datapath.
   function automatic logic f_is_calc(input logic [3:0] t);
      return (t == MD_MULT) || (t == MD_MULTU) || (t == MD_DIV) || (t == MD_DIVU);
   endfunction

   // True for the two's-complement variants.
   function automatic logic f_is_signed(input logic [3:0] t);
      return (t == MD_MULT) || (t == MD_DIV);
   endfunction

   // True for divide variants.
   function automatic logic f_is_div(input logic [3:0] t);
      return (t == MD_DIV) || (t == MD_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_iter_if.sv
// E-stage request/result bundle between the pipeline and the MDU.
// Handshake: Start is the combinational "accept" indication -- an op is
// taken on any rising edge where Start=1 and Req=0. Busy is the registered
// "not ready" indication; while it is high nothing on Req/A/B/MDType is
// consumed and HIOut/LOOut keep their previous values.
interface e_mdu_iter_if #(parameter int WIDTH = 32);
   logic             Req;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       MDType;
   logic [WIDTH-1:0] HIOut;
   logic [WIDTH-1:0] LOOut;
   logic             Start;
   logic             Busy;

   modport master (output Req, A, B, MDType, input HIOut, LOOut, Start, Busy);
   modport slave  (input Req, A, B, MDType, output HIOut, LOOut, Start, Busy);
endinterface

// File: rtl/e_mdu_iter_mdu_step.sv
// One bit-serial iteration: shift-add multiply or restoring divide.
// Multiply: accumulator = {partial product, remaining multiplier bits}.
// Divide:   accumulator = {partial remainder, dividend/quotient bits}.
module e_mdu_iter_mdu_step
   import e_mdu_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_class_e          i_cls,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   output logic [2*WIDTH-1:0] o_acc,
   output logic               o_qbit
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem;
   logic [WIDTH-1:0] w_diff;

   // Compute the next accumulator; for divide the quotient bit slot is left 0
   // and reported separately on o_qbit.
   always_comb begin
      w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
      w_rem  = i_acc[2*WIDTH-1:WIDTH-1];
      // Only used when w_rem >= i_opnd, so the result fits WIDTH bits.
      w_diff = w_rem[WIDTH-1:0] - i_opnd;
      o_qbit = 1'b0;
      o_acc  = {1'b0, i_acc[2*WIDTH-1:1]};
      if (i_cls == OPC_DIV) begin
         o_qbit = (w_rem >= {1'b0, i_opnd});
         if (o_qbit) begin
            o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b0};
         end else begin
            o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
         end
      end else if (i_acc[0]) begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/e_mdu_iter.sv
// Iterative E-stage multiply/divide unit with architectural HI/LO.
// An op runs on operand magnitudes for WIDTH cycles, then one FIX cycle
// applies the sign correction and writes HI/LO.
module e_mdu_iter
   import e_mdu_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic          Clk,
   input logic          Reset,
   e_mdu_iter_if.slave  mdu_bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int W2    = 2 * WIDTH;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_ahold;
   logic [W2-1:0]      r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_qneg;
   logic               r_rneg;

   logic               w_start;
   logic               w_sgn_op;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   op_class_e          w_cls;
   logic [W2-1:0]      w_step_acc;
   logic               w_qbit;
   logic [W2-1:0]      w_acc_nxt;
   logic [W2-1:0]      w_prod_fix;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_hi_fix;
   logic [WIDTH-1:0]   w_lo_fix;

   // Sequencer state register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and Start; Start ignores Req so the hazard unit sees the op.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_start = f_is_calc(mdu_bus.MDType);
            if (w_start && !mdu_bus.Req) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand magnitudes; -MIN wraps to 2^(WIDTH-1), correct as unsigned.
   always_comb begin
      w_sgn_op = f_is_signed(mdu_bus.MDType);
      w_abs_a  = (w_sgn_op && mdu_bus.A[WIDTH-1]) ? -mdu_bus.A : mdu_bus.A;
      w_abs_b  = (w_sgn_op && mdu_bus.B[WIDTH-1]) ? -mdu_bus.B : mdu_bus.B;
      w_cls    = f_is_div(r_op) ? OPC_DIV : OPC_MUL;
      w_acc_nxt = {w_step_acc[W2-1:1], w_step_acc[0] | w_qbit};
   end

   e_mdu_iter_mdu_step #(.WIDTH(WIDTH)) u_mdu_step (
      .i_cls  (w_cls),
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .o_acc  (w_step_acc),
      .o_qbit (w_qbit)
   );

   // Sign correction and divide-by-zero override for the FIX write.
   always_comb begin
      w_rem      = r_acc[W2-1:WIDTH];
      w_quo      = r_acc[WIDTH-1:0];
      w_prod_fix = r_acc;
      w_hi_fix   = w_rem;
      w_lo_fix   = w_quo;
      if (!f_is_div(r_op)) begin
         w_prod_fix = r_qneg ? -r_acc : r_acc;
         w_hi_fix   = w_prod_fix[W2-1:WIDTH];
         w_lo_fix   = w_prod_fix[WIDTH-1:0];
      end else if (r_opnd == '0) begin
         // Divisor magnitude is zero only when B was zero.
         w_hi_fix = r_ahold;
         w_lo_fix = '1;
      end else begin
         w_hi_fix = r_rneg ? -w_rem : w_rem;
         w_lo_fix = r_qneg ? -w_quo : w_quo;
      end
   end

   // Operand capture, iteration, HI/LO writes (FIX result and mthi/mtlo).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_op    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_opnd  <= '0;
         r_ahold <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!mdu_bus.Req) begin
                  if (w_start) begin
                     r_op    <= mdu_bus.MDType;
                     r_ahold <= mdu_bus.A;
                     r_qneg  <= w_sgn_op & (mdu_bus.A[WIDTH-1] ^ mdu_bus.B[WIDTH-1]);
                     r_rneg  <= w_sgn_op & mdu_bus.A[WIDTH-1];
                     r_cnt   <= CNT_W'(WIDTH - 1);
                     // Upper half cleared; lower half seeds the serial operand.
                     if (f_is_div(mdu_bus.MDType)) begin
                        r_opnd <= w_abs_b;
                        r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                     end else begin
                        r_opnd <= w_abs_a;
                        r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                     end
                  end else if (mdu_bus.MDType == MD_MTHI) begin
                     r_hi <= mdu_bus.A;
                  end else if (mdu_bus.MDType == MD_MTLO) begin
                     r_lo <= mdu_bus.A;
                  end
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt - CNT_W'(1);
            end
            S_FIX: begin
               r_hi <= w_hi_fix;
               r_lo <= w_lo_fix;
            end
            default: ;
         endcase
      end
   end

   assign mdu_bus.HIOut = r_hi;
   assign mdu_bus.LOOut = r_lo;
   assign mdu_bus.Start = w_start;
   assign mdu_bus.Busy  = (r_state != S_IDLE);

endmodule
